// File: rtl/vga_timing_pkg.sv
// Shared 640x480 @ 60 Hz timing constants, derived sync windows and the
// coordinate/colour types used across the VGA scan slice.
package vga_timing_pkg;

   localparam int DEF_CLK_DIV     = 4;
   localparam int DEF_H_DISPLAY   = 640;
   localparam int DEF_H_FRONT     = 16;
   localparam int DEF_H_SYNC      = 96;
   localparam int DEF_H_BACK      = 48;
   localparam int DEF_V_DISPLAY   = 480;
   localparam int DEF_V_FRONT     = 10;
   localparam int DEF_V_SYNC      = 2;
   localparam int DEF_V_BACK      = 33;
   localparam bit DEF_SYNC_ACTIVE = 1'b0;

   localparam int H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

   localparam int HS_START = DEF_H_DISPLAY + DEF_H_FRONT;
   localparam int HS_END   = HS_START + DEF_H_SYNC - 1;
   localparam int VS_START = DEF_V_DISPLAY + DEF_V_FRONT;
   localparam int VS_END   = VS_START + DEF_V_SYNC - 1;

   localparam int COORD_W  = 10;
   localparam int COLOUR_W = 12;

   typedef logic [COORD_W-1:0]  coord_t;
   typedef logic [COLOUR_W-1:0] colour_t;

endpackage

// File: rtl/vga_scan_generator_if.sv
// Raster bus between the scan generator (master) and the pixel renderer /
// connector side (slave).
interface vga_scan_generator_if;
   import vga_timing_pkg::*;

   colour_t colour_in;
   logic    ce;
   coord_t  x;
   coord_t  y;
   logic    video_on;
   logic    hsync;
   logic    vsync;
   colour_t vga_rgb;
   logic    frame_tick;

   modport master (
      input  colour_in,
      output ce, x, y, video_on, hsync, vsync, vga_rgb, frame_tick
   );

   modport slave (
      output colour_in,
      input  ce, x, y, video_on, hsync, vsync, vga_rgb, frame_tick
   );

endinterface

// File: rtl/pixel_tick_divider.sv
// Divides the system clock into a one-clk-wide pixel tick every CLK_DIV clocks.
// With CLK_DIV=1 the counter never leaves zero and the tick is always high.
module pixel_tick_divider #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic ce
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div;

   // Free-running modulo-CLK_DIV counter.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (reset)
         div <= '0;
      else if (div == LAST)
         div <= '0;
      else
         div <= div + 1'b1;
   end

   assign ce = (div == LAST);

endmodule

// File: rtl/vga_scan_generator.sv
// 640x480 raster scan generator: pixel tick, x/y counters, sync windows and a
// registered, blanked colour output aligned with the registered syncs.
module vga_scan_generator
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV     = DEF_CLK_DIV,
   parameter int H_DISPLAY   = DEF_H_DISPLAY,
   parameter int H_FRONT     = DEF_H_FRONT,
   parameter int H_SYNC      = DEF_H_SYNC,
   parameter int H_BACK      = DEF_H_BACK,
   parameter int V_DISPLAY   = DEF_V_DISPLAY,
   parameter int V_FRONT     = DEF_V_FRONT,
   parameter int V_SYNC      = DEF_V_SYNC,
   parameter int V_BACK      = DEF_V_BACK,
   parameter bit SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
   input logic                  clk,
   input logic                  reset,
   vga_scan_generator_if.master vga
);

   localparam int LINE_LEN    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int FRAME_LINES = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_FIRST    = H_DISPLAY + H_FRONT;
   localparam int HS_LAST     = HS_FIRST + H_SYNC - 1;
   localparam int VS_FIRST    = V_DISPLAY + V_FRONT;
   localparam int VS_LAST     = VS_FIRST + V_SYNC - 1;
   localparam logic SYNC_ON   = SYNC_ACTIVE;

   if (LINE_LEN > 1024 || FRAME_LINES > 1024) begin : g_bad_totals
      $error("vga_scan_generator: H_TOTAL and V_TOTAL must not exceed 1024");
   end
   if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
      $error("vga_scan_generator: CLK_DIV must be in 1..16");
   end

   logic    ce;
   coord_t  x_q;
   coord_t  y_q;
   logic    video_on;
   logic    hs_win;
   logic    vs_win;
   logic    line_end;
   logic    frame_end;
   colour_t rgb_q;
   logic    hsync_q;
   logic    vsync_q;
   logic    frame_tick_q;

   pixel_tick_divider #(.CLK_DIV(CLK_DIV)) u_div (
      .clk   (clk),
      .reset (reset),
      .ce    (ce)
   );

   assign line_end  = (x_q == coord_t'(LINE_LEN - 1));
   assign frame_end = line_end && (y_q == coord_t'(FRAME_LINES - 1));
   assign video_on  = (x_q < coord_t'(H_DISPLAY)) && (y_q < coord_t'(V_DISPLAY));
   assign hs_win    = (x_q >= coord_t'(HS_FIRST)) && (x_q <= coord_t'(HS_LAST));
   assign vs_win    = (y_q >= coord_t'(VS_FIRST)) && (y_q <= coord_t'(VS_LAST));

   // Raster position: x advances per pixel tick, y advances on the line wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q <= '0;
         y_q <= '0;
      end else if (ce) begin
         if (line_end) begin
            x_q <= '0;
            y_q <= frame_end ? '0 : y_q + 1'b1;
         end else begin
            x_q <= x_q + 1'b1;
         end
      end
   end

   // Output stage: one pixel behind x/y; blanking forces zero so renderer
   // garbage outside the active area never reaches the connector.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rgb_q        <= '0;
         hsync_q      <= ~SYNC_ON;
         vsync_q      <= ~SYNC_ON;
         frame_tick_q <= 1'b0;
      end else begin
         frame_tick_q <= ce && frame_end;
         if (ce) begin
            rgb_q   <= video_on ? vga.colour_in : '0;
            hsync_q <= hs_win ? SYNC_ON : ~SYNC_ON;
            vsync_q <= vs_win ? SYNC_ON : ~SYNC_ON;
         end
      end
   end

   assign vga.ce         = ce;
   assign vga.x          = x_q;
   assign vga.y          = y_q;
   assign vga.video_on   = video_on;
   assign vga.hsync      = hsync_q;
   assign vga.vsync      = vsync_q;
   assign vga.vga_rgb    = rgb_q;
   assign vga.frame_tick = frame_tick_q;

endmodule
